nios_leds_pwm_pio: RTL

//  Avalon-MM slave output port: generalised successor of the 8-bit LED PIO.

---
 rtl/nios_leds_pwm_pio_pkg.sv | 22 ++
 rtl/nios_leds_pwm_pio_if.sv | 21 ++
 rtl/nios_leds_pwm_pio_timebase.sv | 47 ++++
 rtl/nios_leds_pwm_pio.sv | 138 +++++++++++++
 4 files changed

// File: rtl/nios_leds_pwm_pio_pkg.sv
// Shared definitions for the LED PWM PIO: register map, field widths and bus payload.
package nios_pio_pkg;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned BUS_W   = 32;
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned IDX_W   = 5;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_IDX      = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_DUTY     = 3'd6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BUS_W-1:0]  data;
    } bus_wr_t;

endpackage

// File: rtl/nios_leds_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the LED PWM PIO.
interface nios_leds_pwm_pio_if;
    import nios_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_leds_pwm_pio_timebase.sv
// PWM timebase: prescaler producing a tick every PRESCALE+1 clocks and the PWM period counter.
module pio_pwm_timebase
    import nios_pio_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                presc_clr,
    output logic                tick_c,
    output logic                wrap_c,
    output logic [PWM_BITS-1:0] pwm_cnt_q
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PRESC_W-1:0]  presc_cnt_q;
    logic [PRESC_W-1:0]  presc_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_d;

    // Reprogramming the prescaler restarts its phase; the period counter keeps running.
    always_comb begin
        tick_c      = (presc_cnt_q == prescale);
        wrap_c      = tick_c && (pwm_cnt_q == CNT_MAX);
        presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d   = pwm_cnt_q;
        if (tick_c) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
        end
        if (presc_clr) begin
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

endmodule

// File: rtl/nios_leds_pwm_pio.sv
// LED output port with per-channel static level or shadowed PWM duty, atomic set/clear
// and a programmable PWM timebase, on an Avalon-MM slave with zero-wait-state reads.
module nios_leds_pwm_pio
    import nios_pio_pkg::*;
#(
    parameter int unsigned          WIDTH       = 8,
    parameter int unsigned          PWM_BITS    = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
    parameter int unsigned          PRESC_RST   = 49
) (
    input  logic              clk,
    input  logic              reset_n,
    nios_leds_pwm_pio_if.slave bus,
    output logic [WIDTH-1:0]  out_port
);

    bus_wr_t             wr_c;
    logic                wr_en_c;
    logic                presc_clr_c;
    logic                tick_c;
    logic                wrap_c;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [BUS_W-1:0]    readdata_c;
    logic                unused_wdata_c;

    logic [WIDTH-1:0]    data_q,     data_d;
    logic [WIDTH-1:0]    mode_q,     mode_d;
    logic [PRESC_W-1:0]  prescale_q, prescale_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [PWM_BITS-1:0] duty_q   [WIDTH];
    logic [PWM_BITS-1:0] duty_d   [WIDTH];
    logic [PWM_BITS-1:0] active_q [WIDTH];
    logic [PWM_BITS-1:0] active_d [WIDTH];
    logic [WIDTH-1:0]    out_port_q, out_port_d;

    assign wr_c           = '{addr: bus.address, data: bus.writedata};
    assign wr_en_c        = bus.chipselect & ~bus.write_n;
    assign presc_clr_c    = wr_en_c && (wr_c.addr == ADDR_PRESCALE);
    assign unused_wdata_c = ^wr_c.data[BUS_W-1:PRESC_W];

    pio_pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .prescale  (prescale_q),
        .presc_clr (presc_clr_c),
        .tick_c    (tick_c),
        .wrap_c    (wrap_c),
        .pwm_cnt_q (pwm_cnt_q)
    );

    // Register file writes; DUTY writes to an unimplemented channel index are dropped.
    always_comb begin
        data_d     = data_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        idx_d      = idx_q;
        duty_d     = duty_q;
        if (wr_en_c) begin
            case (wr_c.addr)
                ADDR_DATA:     data_d     = wr_c.data[WIDTH-1:0];
                ADDR_MODE:     mode_d     = wr_c.data[WIDTH-1:0];
                ADDR_OUTSET:   data_d     = data_q | wr_c.data[WIDTH-1:0];
                ADDR_OUTCLR:   data_d     = data_q & ~wr_c.data[WIDTH-1:0];
                ADDR_PRESCALE: prescale_d = wr_c.data[PRESC_W-1:0];
                ADDR_IDX:      idx_d      = wr_c.data[IDX_W-1:0];
                ADDR_DUTY: begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            duty_d[i] = wr_c.data[PWM_BITS-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Active duty only follows the programmed duty at the period boundary so no pulse is torn.
    always_comb begin
        active_d = active_q;
        if (wrap_c) begin
            active_d = duty_q;
        end
    end

    always_comb begin
        out_port_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            out_port_d[i] = mode_q[i] ? (pwm_cnt_q < active_q[i]) : data_q[i];
        end
    end

    always_comb begin
        readdata_c = '0;
        case (bus.address)
            ADDR_DATA:     readdata_c = BUS_W'(data_q);
            ADDR_MODE:     readdata_c = BUS_W'(mode_q);
            ADDR_PRESCALE: readdata_c = BUS_W'(prescale_q);
            ADDR_IDX:      readdata_c = BUS_W'(idx_q);
            ADDR_DUTY: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        readdata_c = BUS_W'(duty_q[i]);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.readdata = readdata_c;
    assign out_port     = out_port_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mode_q     <= '0;
            prescale_q <= PRESC_W'(PRESC_RST);
            idx_q      <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                duty_q[i]   <= '0;
                active_q[i] <= '0;
            end
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            mode_q     <= mode_d;
            prescale_q <= prescale_d;
            idx_q      <= idx_d;
            duty_q     <= duty_d;
            active_q   <= active_d;
            out_port_q <= out_port_d;
        end
    end

endmodule
